// File: rtl/lcd_spi_write.sv
// ============================================================================
// Module      : lcd_spi_write
// Description : Serial write engine for a 4-wire SPI LCD port (CS/DC/MOSI/SCK).
//               Sends one 9-bit word {dc, byte} MSB-first in SPI mode 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_spi_write #(
  parameter int CLK_DIV = 2
) (
  input  logic       sys_clk_50MHz,
  input  logic       sys_rst_n,
  input  logic       en_write,
  input  logic [8:0] data,
  output logic       wr_done,
  output logic       busy,
  output logic       lcd_cs,
  output logic       lcd_dc,
  output logic       lcd_sclk,
  output logic       lcd_mosi
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] c_half_last = 8'(CLK_DIV - 1);

  state_t      r_state;
  logic [7:0]  r_half;
  logic [3:0]  r_phase;
  logic [7:0]  r_shift;

  always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state  <= IDLE;
      r_half   <= '0;
      r_phase  <= '0;
      r_shift  <= '0;
      wr_done  <= 1'b0;
      busy     <= 1'b0;
      lcd_cs   <= 1'b1;
      lcd_dc   <= 1'b0;
      lcd_sclk <= 1'b0;
      lcd_mosi <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (en_write) r_state <= SETUP;
        end
        SETUP: begin
          r_shift  <= data[7:0];
          lcd_dc   <= data[8];
          lcd_cs   <= 1'b0;
          lcd_mosi <= data[7];
          lcd_sclk <= 1'b0;
          busy     <= 1'b1;
          r_half   <= '0;
          r_phase  <= '0;
          r_state  <= SHIFT;
        end
        SHIFT: begin
          if (r_half == c_half_last) begin
            r_half  <= '0;
            r_phase <= r_phase + 4'd1;
            if (!r_phase[0]) begin
              lcd_sclk <= 1'b1;
            end else begin
              // Falling SCK edge: present the next lower bit for the next rise.
              lcd_sclk <= 1'b0;
              r_shift  <= {r_shift[6:0], 1'b0};
              lcd_mosi <= r_shift[6];
            end
            if (r_phase == 4'd15) begin
              r_state  <= DONE;
              wr_done  <= 1'b1;
              lcd_cs   <= 1'b1;
              lcd_mosi <= 1'b0;
            end
          end else begin
            r_half <= r_half + 8'd1;
          end
        end
        DONE: begin
          wr_done <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lcd_spi_write.sv
// ============================================================================
// Module      : tb_lcd_spi_write
// Description : Directed self-checking bench for lcd_spi_write (CLK_DIV 2 and 1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lcd_spi_write;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance with CLK_DIV = 2
  logic       rst2_n, en2, done_p2, busy2, cs2, dc2, sclk2, mosi2;
  logic [8:0] data2;
  // Instance with CLK_DIV = 1
  logic       rst1_n, en1, done_p1, busy1, cs1, dc1, sclk1, mosi1;
  logic [8:0] data1;

  lcd_spi_write #(.CLK_DIV(2)) dut2 (
    .sys_clk_50MHz(clk), .sys_rst_n(rst2_n), .en_write(en2), .data(data2),
    .wr_done(done_p2), .busy(busy2), .lcd_cs(cs2), .lcd_dc(dc2),
    .lcd_sclk(sclk2), .lcd_mosi(mosi2)
  );

  lcd_spi_write #(.CLK_DIV(1)) dut1 (
    .sys_clk_50MHz(clk), .sys_rst_n(rst1_n), .en_write(en1), .data(data1),
    .wr_done(done_p1), .busy(busy1), .lcd_cs(cs1), .lcd_dc(dc1),
    .lcd_sclk(sclk1), .lcd_mosi(mosi1)
  );

  // LCD receiver model for the CLK_DIV=2 instance
  logic       p_sclk2 = 1'b0, p_cs2 = 1'b1, dc_first2 = 1'b0, dc_bad2 = 1'b0;
  logic [7:0] rx2 = '0;
  int         nb2 = 0, low2 = 0, high2 = 0, min_gap2 = 1000, nw2 = 0, done2 = 0;
  logic [8:0] wq2[$];
  int         nbq2[$];
  int         lowq2[$];

  always @(negedge clk) begin
    p_sclk2 <= sclk2;
    p_cs2   <= cs2;
    if (done_p2) done2 <= done2 + 1;
    if (!cs2) begin
      if (p_cs2) begin
        if (nw2 > 0 && high2 < min_gap2) min_gap2 <= high2;
        low2      <= 1;
        nb2       <= 0;
        dc_first2 <= dc2;
      end else begin
        low2 <= low2 + 1;
        if (dc2 !== dc_first2) dc_bad2 <= 1'b1;
      end
      if (sclk2 && !p_sclk2) begin
        rx2 <= {rx2[6:0], mosi2};
        nb2 <= (p_cs2 ? 0 : nb2) + 1;
      end
    end else begin
      if (!p_cs2) begin
        wq2.push_back({dc2, rx2});
        nbq2.push_back(nb2);
        lowq2.push_back(low2);
        nw2   <= nw2 + 1;
        high2 <= 1;
      end else begin
        high2 <= high2 + 1;
      end
    end
  end

  // LCD receiver model for the CLK_DIV=1 instance
  logic       p_sclk1 = 1'b0, p_cs1 = 1'b1;
  logic [7:0] rx1 = '0;
  int         nb1 = 0, done1 = 0;
  logic [8:0] wq1[$];
  int         nbq1[$];

  always @(negedge clk) begin
    p_sclk1 <= sclk1;
    p_cs1   <= cs1;
    if (done_p1) done1 <= done1 + 1;
    if (!cs1) begin
      if (sclk1 && !p_sclk1) begin
        rx1 <= {rx1[6:0], mosi1};
        nb1 <= (p_cs1 ? 0 : nb1) + 1;
      end else if (p_cs1) begin
        nb1 <= 0;
      end
    end else if (!p_cs1) begin
      wq1.push_back({dc1, rx1});
      nbq1.push_back(nb1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] got;
    rst2_n = 1'b0; en2 = 1'b1; data2 = 9'h1FF;
    repeat (3) tick();
    got = {cs2, sclk2, mosi2, dc2, done_p2, busy2};
    total++;
    if (got !== 6'b100000) begin
      bad++; $display("FAIL reset_outputs got=%b want=%b", got, 6'b100000);
    end
    rst2_n = 1'b1;
    tick();
    total++;
    if ({cs2, busy2} !== 2'b10) begin
      bad++; $display("FAIL reset_setup_cycle got=%b want=%b", {cs2, busy2}, 2'b10);
    end
    tick();
    total++;
    if ({cs2, busy2, dc2, mosi2} !== 4'b0111) begin
      bad++; $display("FAIL reset_first_latch got=%b want=%b", {cs2, busy2, dc2, mosi2}, 4'b0111);
    end
    en2 = 1'b0;
    repeat (40) tick();
    total++;
    if (done2 !== 1) begin
      bad++; $display("FAIL reset_first_word_done got=%0d want=1", done2);
    end
    wq2.delete(); nbq2.delete(); lowq2.delete();
  endtask

  task automatic test_single(input logic [8:0] w);
    logic [5:0] got, exp;
    logic [8:0] rw;
    int         base;
    base = done2;
    data2 = w; en2 = 1'b1;
    tick();
    tick();
    en2 = 1'b0;
    for (int c = 0; c < 36; c++) begin
      exp = {(c < 32) ? 1'b0 : 1'b1,
             (c < 32) && (((c / 2) % 2) == 1),
             (c < 32) ? w[7 - c / 4] : 1'b0,
             (c == 32),
             (c <= 32),
             w[8]};
      got = {cs2, sclk2, mosi2, done_p2, busy2, dc2};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL single_%h_cycle%0d {cs,sclk,mosi,done,busy,dc} got=%b want=%b", w, c, got, exp);
      end
      data2 = ~data2;
      tick();
    end
    total++;
    if (done2 - base !== 1) begin
      bad++; $display("FAIL single_%h_done_count got=%0d want=1", w, done2 - base);
    end
    total++;
    if (wq2.size() != 1) begin
      bad++; $display("FAIL single_%h_rx_count got=%0d want=1", w, wq2.size());
    end else begin
      rw = wq2.pop_front();
      if (rw !== w) begin
        bad++; $display("FAIL single_%h_rx_word got=%h want=%h", w, rw, w);
      end
      total++;
      if (nbq2[0] !== 8) begin
        bad++; $display("FAIL single_%h_edges got=%0d want=8", w, nbq2[0]);
      end
      total++;
      if (lowq2[0] !== 32) begin
        bad++; $display("FAIL single_%h_cs_low got=%0d want=32", w, lowq2[0]);
      end
    end
    total++;
    if (dc_bad2 !== 1'b0) begin
      bad++; $display("FAIL single_%h_dc_stable got=%b want=0", w, dc_bad2);
    end
    nbq2.delete(); lowq2.delete();
  endtask

  task automatic test_back_to_back();
    logic [8:0] words [3];
    logic [8:0] rw;
    int         idx, base;
    logic       upd;
    words[0] = 9'h011; words[1] = 9'h036; words[2] = 9'h1A0;
    base = done2; min_gap2 = 1000; idx = 0; upd = 1'b0;
    data2 = words[0]; en2 = 1'b1;
    for (int cyc = 0; cyc < 400 && idx < 3; cyc++) begin
      tick();
      if (upd) begin data2 = words[idx]; upd = 1'b0; end
      if (done_p2) begin
        idx++;
        if (idx == 3) en2 = 1'b0;
        else upd = 1'b1;
      end
    end
    en2 = 1'b0;
    total++;
    if (idx !== 3) begin
      bad++; $display("FAIL b2b_timeout got=%0d want=3", idx);
    end
    repeat (10) tick();
    total++;
    if (done2 - base !== 3) begin
      bad++; $display("FAIL b2b_done_count got=%0d want=3", done2 - base);
    end
    total++;
    if (wq2.size() != 3) begin
      bad++; $display("FAIL b2b_rx_count got=%0d want=3", wq2.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        rw = wq2.pop_front();
        total++;
        if (rw !== words[i] || nbq2[i] !== 8) begin
          bad++; $display("FAIL b2b_word%0d got=%h/%0d want=%h/8", i, rw, nbq2[i], words[i]);
        end
      end
    end
    total++;
    if (min_gap2 < 2) begin
      bad++; $display("FAIL b2b_cs_gap got=%0d want>=2", min_gap2);
    end
    nbq2.delete(); lowq2.delete();
  endtask

  task automatic test_abort();
    int         base;
    logic [8:0] rw;
    base = done2;
    data2 = 9'h036; en2 = 1'b1;
    tick();
    tick();
    repeat (10) tick();   // SHIFT phase 5
    en2 = 1'b0;
    repeat (60) tick();
    total++;
    if (done2 - base !== 1) begin
      bad++; $display("FAIL abort_done_count got=%0d want=1", done2 - base);
    end
    total++;
    if ({cs2, busy2} !== 2'b10) begin
      bad++; $display("FAIL abort_idle got=%b want=%b", {cs2, busy2}, 2'b10);
    end
    total++;
    if (wq2.size() != 1) begin
      bad++; $display("FAIL abort_rx_count got=%0d want=1", wq2.size());
    end else begin
      rw = wq2.pop_front();
      if (rw !== 9'h036) begin
        bad++; $display("FAIL abort_rx_word got=%h want=036", rw);
      end
    end
    nbq2.delete(); lowq2.delete();
  endtask

  task automatic test_reset_mid();
    int         base;
    logic [8:0] rw;
    data1 = 9'h036; en1 = 1'b1;
    tick();
    tick();
    repeat (7) tick();    // SHIFT phase 7, SCK high
    total++;
    if (sclk1 !== 1'b1) begin
      bad++; $display("FAIL midrst_sclk_before got=%b want=1", sclk1);
    end
    base = done1;
    rst1_n = 1'b0; en1 = 1'b0;
    #1;
    total++;
    if ({cs1, sclk1, mosi1, busy1, done_p1} !== 5'b10000) begin
      bad++; $display("FAIL midrst_async got=%b want=%b", {cs1, sclk1, mosi1, busy1, done_p1}, 5'b10000);
    end
    repeat (3) tick();
    rst1_n = 1'b1;
    repeat (20) tick();
    total++;
    if (done1 !== base) begin
      bad++; $display("FAIL midrst_no_done got=%0d want=%0d", done1, base);
    end
    wq1.delete(); nbq1.delete();
    base = done1;
    data1 = 9'h02C; en1 = 1'b1;
    tick();
    tick();
    en1 = 1'b0;
    repeat (25) tick();
    total++;
    if (done1 - base !== 1) begin
      bad++; $display("FAIL midrst_next_done got=%0d want=1", done1 - base);
    end
    total++;
    if (wq1.size() != 1) begin
      bad++; $display("FAIL midrst_next_count got=%0d want=1", wq1.size());
    end else begin
      rw = wq1.pop_front();
      if (rw !== 9'h02C || nbq1[0] !== 8) begin
        bad++; $display("FAIL midrst_next_word got=%h/%0d want=02c/8", rw, nbq1[0]);
      end
    end
  endtask

  initial begin
    rst2_n = 1'b0; en2 = 1'b0; data2 = '0;
    rst1_n = 1'b0; en1 = 1'b0; data1 = '0;
    repeat (2) tick();
    rst1_n = 1'b1;
    test_reset();
    test_single(9'h011);
    test_single(9'h1A0);
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
